// File: rtl/beat_pkg.sv
// beat_pkg: shared types and defaults for the beat record/playback sequencer.
//   - beat_state_e : controller state, encoding doubles as the LED state code
//   - ADDR_W_DEF / DATA_W_DEF : default RAM address / key code widths
//   - IDLE_CODE_DEF : key code meaning "no key" (ASCII space)
package beat_pkg;

  localparam int         ADDR_W_DEF    = 8;
  localparam int         DATA_W_DEF    = 7;
  localparam logic [6:0] IDLE_CODE_DEF = 7'd32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } beat_state_e;

endpackage

// File: rtl/beat_tick_gen.sv
// beat_tick_gen: playback tick divider. Down-counter reloaded with TICK_DIV-1;
// tick is high for one cycle each time the counter reaches zero while enabled.
// Ports:
//   clk, resetn : clock, async active-low reset
//   clr         : synchronous reload (holds the counter at TICK_DIV-1)
//   en          : count enable
//   tick        : one-cycle tick, combinational from the counter
module beat_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      cnt <= RELOAD;
    else if (clr)     cnt <= RELOAD;
    else if (en)      cnt <= tick ? RELOAD : cnt - 1'b1;
  end

endmodule

// File: rtl/beat_seq_ctrl.sv
// beat_seq_ctrl: record/playback sequencer owning the single-port beat RAM.
// RECORD writes one entry per change of the key code; PLAYBACK reads the
// entries back at one per TICK_DIV cycles. One FSM arbitrates the RAM port.
// Optional macro: LOOP_PLAYBACK_EN -- playback wraps to entry 0 until stopped;
// otherwise playback returns to IDLE after the last entry has been presented.
// Ports:
//   clk, resetn         : clock, async active-low reset
//   rec_req, play_req   : level requests, acted on at their rising edge
//   stop_req            : level, forces IDLE
//   ascii               : current key code
//   mem_rdata           : RAM read data, valid one cycle after mem_addr
//   mem_addr/wdata/wren : registered RAM controls (wren is a one-cycle pulse)
//   play_code/play_valid: last code played back / one-cycle update strobe
//   rec_len             : number of stored entries (ADDR_W+1 bits)
//   state_o             : 0 IDLE, 1 RECORD, 2 PLAYBACK
module beat_seq_ctrl
  import beat_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                TICK_DIV  = 50000000,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEF)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic [DATA_W-1:0] ascii,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic [DATA_W-1:0] play_code,
  output logic              play_valid,
  output logic [ADDR_W:0]   rec_len,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  beat_state_e       state;
  logic              rec_q, play_q;
  logic              rec_edge, play_edge;
  logic [DATA_W-1:0] prev_code;
  logic [ADDR_W-1:0] play_ptr;
  logic              ptr_last;
  logic              done;      // last entry has been issued (non-loop mode)
  logic [1:0]        vld_pipe;  // [0]: address on the RAM, [1]: data on mem_rdata
  logic              tick;

  assign rec_edge  = rec_req  & ~rec_q;
  assign play_edge = play_req & ~play_q;
  assign ptr_last  = ({1'b0, play_ptr} == (rec_len - ONE));
  assign state_o   = state;

  // Divider held in reload outside PLAYBACK, so it restarts on every entry.
  beat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state != ST_PLAY),
    .en     ((state == ST_PLAY) && !done),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      rec_q      <= 1'b0;
      play_q     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      play_code  <= IDLE_CODE;
      play_valid <= 1'b0;
      rec_len    <= '0;
      prev_code  <= IDLE_CODE;
      play_ptr   <= '0;
      done       <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      rec_q      <= rec_req;
      play_q     <= play_req;
      mem_wren   <= 1'b0;
      play_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          vld_pipe <= '0;
          done     <= 1'b0;
          if (!stop_req) begin
            if (rec_edge) begin
              rec_len   <= '0;
              prev_code <= IDLE_CODE;
              state     <= ST_RECORD;
            end else if (play_edge && rec_len != '0) begin
              play_ptr <= '0;
              state    <= ST_PLAY;
            end
          end
        end
        ST_RECORD: begin
          if (rec_len == FULL) begin
            state <= ST_IDLE;
          end else begin
            // A change seen in the stop cycle is still committed.
            if (ascii != prev_code) begin
              mem_addr  <= rec_len[ADDR_W-1:0];
              mem_wdata <= ascii;
              mem_wren  <= 1'b1;
              rec_len   <= rec_len + ONE;
              prev_code <= ascii;
            end
            if (stop_req) state <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (stop_req) begin
            // Drop any read still in the pipe.
            state    <= ST_IDLE;
            vld_pipe <= '0;
          end else begin
            vld_pipe <= {vld_pipe[0], tick};
            if (tick) begin
              mem_addr <= play_ptr;
`ifdef LOOP_PLAYBACK_EN
              play_ptr <= ptr_last ? '0 : play_ptr + 1'b1;
`else
              play_ptr <= play_ptr + 1'b1;
              if (ptr_last) done <= 1'b1;
`endif
            end
            if (vld_pipe[1]) begin
              play_code  <= mem_rdata;
              play_valid <= 1'b1;
            end
`ifndef LOOP_PLAYBACK_EN
            // TICK_DIV >= 4 keeps the last strobe ahead of any further tick.
            if (play_valid && done) state <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_seq_ctrl.sv
// tb_beat_seq_ctrl: directed bench for beat_seq_ctrl. Main instance uses the
// default widths with TICK_DIV=4 backed by a synchronous RAM model; a second
// instance with ADDR_W=2 shares the stimulus and covers the full-memory case.
module tb_beat_seq_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rec_req = 1'b0, play_req = 1'b0, stop_req = 1'b0;
  logic [6:0] ascii = 7'd32;

  logic [6:0] mem_rdata, mem_wdata, play_code;
  logic [7:0] mem_addr;
  logic       mem_wren, play_valid;
  logic [8:0] rec_len;
  logic [1:0] state_o;

  logic [6:0] s_wdata, s_code;
  logic [1:0] s_addr, s_state;
  logic       s_wren, s_valid;
  logic [2:0] s_rec_len;

  logic [6:0] ram [0:255];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  beat_seq_ctrl #(.ADDR_W(8), .DATA_W(7), .TICK_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .rec_req(rec_req), .play_req(play_req),
    .stop_req(stop_req), .ascii(ascii), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .play_code(play_code), .play_valid(play_valid), .rec_len(rec_len),
    .state_o(state_o)
  );

  beat_seq_ctrl #(.ADDR_W(2), .DATA_W(7), .TICK_DIV(4)) dut_s (
    .clk(clk), .resetn(resetn), .rec_req(rec_req), .play_req(play_req),
    .stop_req(stop_req), .ascii(ascii), .mem_rdata(7'd0),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_wren(s_wren),
    .play_code(s_code), .play_valid(s_valid), .rec_len(s_rec_len),
    .state_o(s_state)
  );

  // Single-port synchronous RAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " state"},      int'(state_o),    0);
    chk({tag, " mem_addr"},   int'(mem_addr),   0);
    chk({tag, " mem_wdata"},  int'(mem_wdata),  0);
    chk({tag, " mem_wren"},   int'(mem_wren),   0);
    chk({tag, " play_code"},  int'(play_code),  32);
    chk({tag, " play_valid"}, int'(play_valid), 0);
    chk({tag, " rec_len"},    int'(rec_len),    0);
  endtask

  typedef struct {
    logic       rec, play, stop;
    logic [6:0] code;
    logic       wren;
    logic [7:0] addr;
    logic [6:0] wdata;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [8];
  int   codes [3];
  int   s_seq [5];

  initial begin
    // inputs applied, then expected outputs after the capturing edge
    tbl[0] = '{1'b1, 1'b0, 1'b0, 7'd32, 1'b0, 8'd0, 7'd0,  2'd1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 7'd32, 1'b0, 8'd0, 7'd0,  2'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 7'd65, 1'b1, 8'd0, 7'd65, 2'd1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 7'd65, 1'b0, 8'd0, 7'd65, 2'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 7'd66, 1'b1, 8'd1, 7'd66, 2'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 7'd32, 1'b1, 8'd2, 7'd32, 2'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 7'd32, 1'b0, 8'd2, 7'd32, 2'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 7'd32, 1'b0, 8'd2, 7'd32, 2'd0};
    codes = '{65, 66, 32};
    s_seq = '{65, 66, 67, 68, 69};

    // reset
    repeat (3) @(negedge clk);
    chk_reset("reset");
    resetn = 1'b1;
    cyc();

    // play request with nothing recorded is ignored
    play_req = 1'b1;
    cyc();
    chk("empty play state", int'(state_o), 0);
    play_req = 1'b0;
    cyc();
    chk("empty play state hold", int'(state_o), 0);

    // record 32,65,65,66,32 then stop
    for (int i = 0; i < 8; i++) begin
      rec_req = tbl[i].rec; play_req = tbl[i].play;
      stop_req = tbl[i].stop; ascii = tbl[i].code;
      cyc();
      chk($sformatf("rec[%0d] wren", i),  int'(mem_wren),  int'(tbl[i].wren));
      chk($sformatf("rec[%0d] addr", i),  int'(mem_addr),  int'(tbl[i].addr));
      chk($sformatf("rec[%0d] wdata", i), int'(mem_wdata), int'(tbl[i].wdata));
      chk($sformatf("rec[%0d] state", i), int'(state_o),   int'(tbl[i].st));
    end
    chk("rec_len after record", int'(rec_len), 3);

    // playback: k counts cycles from the first PLAYBACK cycle
    play_req = 1'b1;
    cyc();
    chk("play entry state", int'(state_o), 2);
    play_req = 1'b0;
`ifdef LOOP_PLAYBACK_EN
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("loop k%0d valid", k), int'(play_valid),
          int'(k >= 6 && (k - 6) % 4 == 0));
      if (k >= 6 && (k - 6) % 4 == 0)
        chk($sformatf("loop k%0d code", k), int'(play_code), codes[((k - 6) / 4) % 3]);
      chk($sformatf("loop k%0d state", k), int'(state_o), 2);
    end
    // read issued at k=19 is in flight now
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    for (int k = 21; k <= 23; k++) begin
      chk($sformatf("loop stop k%0d valid", k), int'(play_valid), 0);
      chk($sformatf("loop stop k%0d state", k), int'(state_o), 0);
      cyc();
    end
`else
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk($sformatf("play k%0d valid", k), int'(play_valid),
          int'(k == 6 || k == 10 || k == 14));
      if (k == 6 || k == 10 || k == 14)
        chk($sformatf("play k%0d code", k), int'(play_code), codes[(k - 6) / 4]);
      chk($sformatf("play k%0d state", k), int'(state_o), (k <= 14) ? 2 : 0);
    end
`endif
    chk("rec_len after play", int'(rec_len), 3);

    // simultaneous rec and play edges: RECORD wins
    rec_req = 1'b1; play_req = 1'b1; ascii = 7'd32;
    cyc();
    chk("priority state", int'(state_o), 1);
    chk("priority rec_len", int'(rec_len), 0);
    rec_req = 1'b0; play_req = 1'b0;

    // small instance fills at 4 entries; 5th change not written
    for (int i = 0; i < 5; i++) begin
      ascii = s_seq[i][6:0];
      cyc();
      if (i < 4) begin
        chk($sformatf("full[%0d] wren", i),    int'(s_wren),    1);
        chk($sformatf("full[%0d] addr", i),    int'(s_addr),    i);
        chk($sformatf("full[%0d] wdata", i),   int'(s_wdata),   s_seq[i]);
        chk($sformatf("full[%0d] rec_len", i), int'(s_rec_len), i + 1);
      end else begin
        chk("full 5th wren",  int'(s_wren),    0);
        chk("full 5th state", int'(s_state),   0);
        chk("full rec_len",   int'(s_rec_len), 4);
        chk("full addr hold", int'(s_addr),    3);
      end
    end
    cyc();
    chk("full idle wren", int'(s_wren), 0);
    chk("main still recording", int'(state_o), 1);
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    chk("stop state", int'(state_o), 0);
    chk("main rec_len 5", int'(rec_len), 5);

    // reset in the middle of RECORD after two writes
    ascii = 7'd32; rec_req = 1'b1;
    cyc();
    rec_req = 1'b0; ascii = 7'd70;
    cyc();
    chk("mid wr0 addr", int'(mem_addr), 0);
    ascii = 7'd71;
    cyc();
    chk("mid wr1 wren", int'(mem_wren), 1);
    chk("mid wr1 addr", int'(mem_addr), 1);
    chk("mid rec_len", int'(rec_len), 2);
    resetn = 1'b0;
    #1;
    chk_reset("mid reset");
    chk("mid reset small rec_len", int'(s_rec_len), 0);
    cyc();
    resetn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
